// File: rtl/seg_scan_driver_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg_pkg : shared constants and scan-state type for seg_scan_driver  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package seg_pkg;

    localparam int         SEG_DIGITS = 4;
    localparam int         SEG_DIG_W  = $clog2(SEG_DIGITS);
    localparam logic [7:0] SEG_OFF    = 8'hFF;
    localparam logic [3:0] AN_OFF     = 4'hF;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

endpackage
`default_nettype wire

// File: rtl/seg_scan_driver_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg_scan_driver_if : digit patterns in, anode/cathode pins out     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface seg_scan_driver_if;

    logic [7:0] seg0;
    logic [7:0] seg1;
    logic [7:0] seg2;
    logic [7:0] seg3;
    logic [3:0] blinkMask;
    logic [3:0] an;
    logic [7:0] cathode;
    logic       frameTick;

    modport master (
        output seg0, seg1, seg2, seg3, blinkMask,
        input  an, cathode, frameTick
    );

    modport slave (
        input  seg0, seg1, seg2, seg3, blinkMask,
        output an, cathode, frameTick
    );

endinterface
`default_nettype wire

// File: rtl/seg_scan_driver_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg_scan_timer : per-digit slot counter and digit index            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  wire logic                 Clk100M,
    input  wire logic                 reset,
    output logic [SEG_DIG_W-1:0]      digit_o,
    output logic                      blankDone_o,
    output logic                      slotEnd_o
);

    localparam int               c_CW         = $clog2(SCAN_DIV);
    localparam logic [c_CW-1:0]  c_LAST       = c_CW'(SCAN_DIV - 1);
    localparam logic [c_CW-1:0]  c_BLANK_LAST = c_CW'(BLANK_CYCLES - 1);

    logic [c_CW-1:0]      count_q, count_d;
    logic [SEG_DIG_W-1:0] digit_q, digit_d;

    always_ff @(posedge Clk100M or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            digit_q <= '0;
        end else begin
            count_q <= count_d;
            digit_q <= digit_d;
        end
    end

    always_comb begin
        count_d = count_q + 1'b1;
        digit_d = digit_q;
        if (slotEnd_o) begin
            count_d = '0;
            digit_d = digit_q + 1'b1;
        end
    end

    assign blankDone_o = (count_q == c_BLANK_LAST);
    assign slotEnd_o   = (count_q == c_LAST);
    assign digit_o     = digit_q;

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg_scan_driver : 4-digit 7-seg scanner, per-frame input snapshot,  |
// | blanking gap per digit; optional blink with SEG_BLINK_EN. Rev 1.0  |
// +--------------------------------------------------------------------+
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_FRAMES = 125
) (
    input  wire logic          Clk100M,
    input  wire logic          reset,
    seg_scan_driver_if.slave   bus
);

    logic [SEG_DIG_W-1:0] w_digit;
    logic                 w_blankDone;
    logic                 w_slotEnd;
    logic                 w_snap;
    logic                 w_hide;
    logic [7:0]           w_seg [SEG_DIGITS];

    scan_state_e          state_q, state_d;
    logic [7:0]           shadow_q [SEG_DIGITS];
    logic                 firstDrive_q;
    logic [3:0]           an_q, an_d;
    logic [7:0]           cathode_q, cathode_d;
    logic                 frameTick_q;

    seg_scan_timer #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .Clk100M     (Clk100M),
        .reset       (reset),
        .digit_o     (w_digit),
        .blankDone_o (w_blankDone),
        .slotEnd_o   (w_slotEnd)
    );

    assign w_seg[0] = bus.seg0;
    assign w_seg[1] = bus.seg1;
    assign w_seg[2] = bus.seg2;
    assign w_seg[3] = bus.seg3;

    // The frame snapshot is taken one edge before digit 0's first drive cycle
    assign w_snap = (state_q == BLANK) && w_blankDone && (w_digit == '0);

    always_ff @(posedge Clk100M or negedge reset) begin
        if (!reset) begin
            state_q      <= BLANK;
            firstDrive_q <= 1'b0;
            an_q         <= AN_OFF;
            cathode_q    <= SEG_OFF;
            frameTick_q  <= 1'b0;
            for (int i = 0; i < SEG_DIGITS; i++) shadow_q[i] <= SEG_OFF;
        end else begin
            state_q      <= state_d;
            firstDrive_q <= w_snap;
            an_q         <= an_d;
            cathode_q    <= cathode_d;
            frameTick_q  <= firstDrive_q;
            if (w_snap) begin
                for (int i = 0; i < SEG_DIGITS; i++) shadow_q[i] <= w_seg[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        an_d      = AN_OFF;
        cathode_d = SEG_OFF;
        unique case (state_q)
            BLANK: begin
                if (w_blankDone) state_d = DRIVE;
            end
            DRIVE: begin
                if (w_slotEnd) state_d = BLANK;
                if (!w_hide) begin
                    an_d      = ~(4'b0001 << w_digit);
                    cathode_d = shadow_q[w_digit];
                end
            end
            default: state_d = BLANK;
        endcase
    end

`ifdef SEG_BLINK_EN
    localparam int              c_FW    = $clog2(BLINK_FRAMES + 1);
    localparam logic [c_FW-1:0] c_FLAST = c_FW'(BLINK_FRAMES - 1);

    logic [c_FW-1:0] fcnt_q, fcnt_d;
    logic            phase_q, phase_d;
    logic [3:0]      mask_q;
    logic            w_frameEnd;

    assign w_frameEnd = w_slotEnd && (w_digit == SEG_DIG_W'(SEG_DIGITS - 1));

    always_ff @(posedge Clk100M or negedge reset) begin
        if (!reset) begin
            fcnt_q  <= '0;
            phase_q <= 1'b0;
            mask_q  <= '0;
        end else begin
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
            if (w_snap) mask_q <= bus.blinkMask;
        end
    end

    always_comb begin
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (w_frameEnd) begin
            if (fcnt_q == c_FLAST) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d  = fcnt_q + 1'b1;
            end
        end
    end

    assign w_hide = phase_q & mask_q[w_digit];
`else
    logic w_unused_blink;
    assign w_unused_blink = ^{bus.blinkMask, BLINK_FRAMES[0]};
    assign w_hide         = 1'b0;
`endif

    assign bus.an        = an_q;
    assign bus.cathode   = cathode_q;
    assign bus.frameTick = frameTick_q;

endmodule
`default_nettype wire
